// File: rtl/oled_pkg.sv
// Shared constants and pixel types for the 96x64 RGB565 PMOD OLED pixel path.
package oled_pkg;

    localparam int OLED_WIDTH  = 32'd96;
    localparam int OLED_HEIGHT = 32'd64;
    localparam int OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;
    localparam int PIXEL_IDX_W = 32'd13;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t COLOR_BLACK        = 16'h0000;
    localparam rgb565_t COLOR_RED          = 16'hF800;
    localparam rgb565_t COLOR_GREEN        = 16'h07E0;
    localparam rgb565_t COLOR_BLUE         = 16'h001F;
    localparam rgb565_t COLOR_WHITE        = 16'hFFFF;
    localparam rgb565_t IDLE_COLOR_DEFAULT = COLOR_BLACK;

endpackage

// File: rtl/oled_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from start, wrapping modulo N.
module oled_rr_pick #(
    parameter int N = 32'd4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int           pos_s;
            logic [W-1:0] cand_s;
            pos_s = int'(start) + i;
            if (pos_s >= N) begin
                pos_s = pos_s - N;
            end else begin
                pos_s = pos_s;
            end
            cand_s = pos_s[W-1:0];
            if (req[cand_s]) begin
                found = 1'b1;
                idx   = cand_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/oled_frame_arbiter.sv
// Frame-aligned round-robin arbiter sharing the OLED pixel stream between
// several pixel sources, with a per-owner frame quota while others wait.
module oled_frame_arbiter
    import oled_pkg::*;
#(
    parameter int      NUM_CLIENTS = 32'd4,
    parameter int      MAX_FRAMES  = 32'd60,
    parameter rgb565_t IDLE_COLOR  = IDLE_COLOR_DEFAULT,
    localparam int     OWNER_W     = $clog2(NUM_CLIENTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_begin,
    input  logic [PIXEL_IDX_W-1:0]    pixel_index,
    output logic [15:0]               pixel_data,
    input  logic [NUM_CLIENTS-1:0]    req,
    input  logic [16*NUM_CLIENTS-1:0] client_pixel_data,
    output logic [PIXEL_IDX_W-1:0]    client_pixel_index,
    output logic [NUM_CLIENTS-1:0]    grant,
    output logic                      grant_valid,
    output logic [OWNER_W-1:0]        owner_id,
    output logic                      owner_frame_start,
    output logic [7:0]                frames_held
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_OWNED = 1'b1;

    function automatic logic [OWNER_W-1:0] inc_mod(input logic [OWNER_W-1:0] x);
        if (int'(x) == NUM_CLIENTS - 32'd1) begin
            return '0;
        end else begin
            return x + OWNER_W'(1'b1);
        end
    endfunction

    function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [OWNER_W-1:0] i);
        logic [NUM_CLIENTS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    logic                   state_r;
    logic [OWNER_W-1:0]     owner_r;
    logic [OWNER_W-1:0]     last_owner_r;
    logic [7:0]             frames_held_r;
    logic [NUM_CLIENTS-1:0] grant_r;
    logic                   ofs_r;

    logic                   nxt_state_s;
    logic [OWNER_W-1:0]     nxt_owner_s;
    logic [OWNER_W-1:0]     nxt_last_s;
    logic [7:0]             nxt_frames_s;

    logic [OWNER_W-1:0]     rel_start_s;
    logic                   rel_found_s;
    logic [OWNER_W-1:0]     rel_idx_s;
    logic [NUM_CLIENTS-1:0] others_s;
    logic                   rot_found_s;
    logic [OWNER_W-1:0]     rot_idx_s;
    logic                   quota_hit_s;

    logic [15:0]            slice_s [NUM_CLIENTS];

    assign rel_start_s = (state_r == ST_OWNED) ? inc_mod(owner_r) : inc_mod(last_owner_r);
    assign others_s    = req & ~onehot(owner_r);
    assign quota_hit_s = ({1'b0, frames_held_r} + 9'd1) >= 9'(MAX_FRAMES);

    // Grant from idle, or hand over when the owner has dropped its request.
    oled_rr_pick #(.N(NUM_CLIENTS), .W(OWNER_W)) u_pick_release (
        .req   (req),
        .start (rel_start_s),
        .found (rel_found_s),
        .idx   (rel_idx_s)
    );

    // Quota rotation only considers clients other than the current owner.
    oled_rr_pick #(.N(NUM_CLIENTS), .W(OWNER_W)) u_pick_rotate (
        .req   (others_s),
        .start (inc_mod(owner_r)),
        .found (rot_found_s),
        .idx   (rot_idx_s)
    );

    // Ownership decision applied at the next frame boundary.
    always_comb begin
        nxt_state_s  = state_r;
        nxt_owner_s  = owner_r;
        nxt_last_s   = last_owner_r;
        nxt_frames_s = frames_held_r;
        case (state_r)
            ST_IDLE: begin
                if (rel_found_s) begin
                    nxt_state_s  = ST_OWNED;
                    nxt_owner_s  = rel_idx_s;
                    nxt_last_s   = rel_idx_s;
                    nxt_frames_s = 8'd0;
                end else begin
                    nxt_state_s  = ST_IDLE;
                end
            end
            ST_OWNED: begin
                if (!req[owner_r]) begin
                    if (rel_found_s) begin
                        nxt_owner_s  = rel_idx_s;
                        nxt_last_s   = rel_idx_s;
                        nxt_frames_s = 8'd0;
                    end else begin
                        nxt_state_s  = ST_IDLE;
                        nxt_owner_s  = '0;
                        nxt_frames_s = 8'd0;
                    end
                end else if (rot_found_s && quota_hit_s) begin
                    nxt_owner_s  = rot_idx_s;
                    nxt_last_s   = rot_idx_s;
                    nxt_frames_s = 8'd0;
                end else begin
                    nxt_frames_s = (frames_held_r == 8'hFF) ? 8'hFF : frames_held_r + 8'd1;
                end
            end
            default: begin
                nxt_state_s  = ST_IDLE;
                nxt_owner_s  = '0;
                nxt_frames_s = 8'd0;
            end
        endcase
    end

    // Arbitration registers: move only on frame_begin, reset has priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            owner_r       <= '0;
            last_owner_r  <= OWNER_W'(NUM_CLIENTS - 32'd1);
            frames_held_r <= 8'd0;
            grant_r       <= '0;
            ofs_r         <= 1'b0;
        end else if (frame_begin) begin
            state_r       <= nxt_state_s;
            owner_r       <= nxt_owner_s;
            last_owner_r  <= nxt_last_s;
            frames_held_r <= nxt_frames_s;
            grant_r       <= (nxt_state_s == ST_OWNED) ? onehot(nxt_owner_s) : '0;
            ofs_r         <= (nxt_state_s == ST_OWNED);
        end else begin
            ofs_r         <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_slice
        assign slice_s[k] = client_pixel_data[16*k +: 16];
    end

    // Pixel mux; the select comes from frame-stable registers.
    always_comb begin
        pixel_data = IDLE_COLOR;
        if (state_r == ST_OWNED) begin
            pixel_data = slice_s[owner_r];
        end else begin
            pixel_data = IDLE_COLOR;
        end
    end

    assign client_pixel_index = pixel_index;
    assign grant              = grant_r;
    assign grant_valid        = state_r;
    assign owner_id           = owner_r;
    assign owner_frame_start  = ofs_r;
    assign frames_held        = frames_held_r;

endmodule

// File: tb/tb_oled_frame_arbiter.sv
// Scoreboard bench for oled_frame_arbiter: a rule-level model predicts each
// frame-boundary outcome, a negedge monitor compares DUT outputs every cycle.
module tb_oled_frame_arbiter;
    import oled_pkg::*;

    localparam int N    = 4;
    localparam int MAXF = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_begin = 1'b0;
    logic [12:0] pixel_index = 13'd0;
    logic [15:0] pixel_data;
    logic [3:0]  req = 4'b1111;
    logic [63:0] client_pixel_data;
    logic [12:0] client_pixel_index;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  owner_id;
    logic        owner_frame_start;
    logic [7:0]  frames_held;

    oled_frame_arbiter #(.NUM_CLIENTS(N), .MAX_FRAMES(MAXF), .IDLE_COLOR(16'h0000)) dut (
        .clk                (clk),
        .reset              (reset),
        .frame_begin        (frame_begin),
        .pixel_index        (pixel_index),
        .pixel_data         (pixel_data),
        .req                (req),
        .client_pixel_data  (client_pixel_data),
        .client_pixel_index (client_pixel_index),
        .grant              (grant),
        .grant_valid        (grant_valid),
        .owner_id           (owner_id),
        .owner_frame_start  (owner_frame_start),
        .frames_held        (frames_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] grant;
        int         owner;
        int         fh;
        bit         ofs;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       cur;
    bit         started = 1'b0;
    logic       fb_seen = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [15:0] cdata [4];
    int         qseq [7] = '{0, 0, 0, 2, 2, 2, 0};

    // Reference model state
    bit m_owned;
    int m_owner, m_last, m_fh;

    assign client_pixel_data = {cdata[3], cdata[2], cdata[1], cdata[0]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [3:0] r, input int start);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (start + i) % N;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input bit rst);
        exp_t e;
        int   w;
        if (rst) begin
            m_owned = 0; m_owner = 0; m_last = N - 1; m_fh = 0;
        end else if (!m_owned) begin
            w = rr(req, m_last + 1);
            if (w >= 0) begin
                m_owned = 1; m_owner = w; m_last = w; m_fh = 0;
            end
        end else if (!req[m_owner]) begin
            w = rr(req, m_owner + 1);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_fh = 0;
            end else begin
                m_owned = 0; m_owner = 0; m_fh = 0;
            end
        end else if ((req & ~(4'b0001 << m_owner)) != 4'b0000 && m_fh + 1 >= MAXF) begin
            w = rr(req & ~(4'b0001 << m_owner), m_owner + 1);
            m_owner = w; m_last = w; m_fh = 0;
        end else begin
            m_fh = (m_fh >= 255) ? 255 : m_fh + 1;
        end
        e.grant = m_owned ? (4'b0001 << m_owner) : 4'b0000;
        e.owner = m_owner;
        e.fh    = m_fh;
        e.ofs   = !rst && m_owned;
        sb_q.push_back(e);
    endtask

    task automatic cycle(input bit fb, input bit rst);
        frame_begin = fb;
        reset       = rst;
        if (fb || rst) model_step(rst);
        @(posedge clk);
        #1;
        frame_begin = 1'b0;
        reset       = 1'b0;
        pixel_index = 13'($urandom_range(0, OLED_PIXELS - 1));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0);
    endtask

    always @(posedge clk) fb_seen <= frame_begin | reset;

    // Monitor: pop an expectation on each boundary, check steady state otherwise.
    initial forever begin
        @(negedge clk);
        if (fb_seen) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                cur = sb_q.pop_front();
                started = 1'b1;
                check("ofs_pulse", owner_frame_start, cur.ofs);
            end
        end else if (started) begin
            check("ofs_quiet", owner_frame_start, 32'd0);
        end
        if (started) begin
            check("grant", grant, cur.grant);
            check("grant_valid", grant_valid, (cur.grant != 4'b0000));
            check("owner_id", owner_id, cur.owner);
            check("frames_held", frames_held, cur.fh);
            check("pixel_data", pixel_data, (cur.grant != 4'b0000) ? cdata[cur.owner] : 16'h0000);
            check("pix_index", client_pixel_index, pixel_index);
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < N; k++) cdata[k] = 16'($urandom);

        // Reset with all clients requesting
        req = 4'b1111;
        repeat (3) cycle(1'b0, 1'b1);
        check("rst_grant", grant, 32'd0);
        check("rst_pixel", pixel_data, 32'h0000);
        idle(4);
        cycle(1'b1, 1'b0);
        check("first_grant", grant, 32'b0001);

        // Frame-aligned grant
        req = 4'b0000;
        idle(3);
        cycle(1'b1, 1'b0);
        check("release_idle", grant, 32'd0);
        req = 4'b0010;
        cdata[1] = 16'hF800;
        idle(5);
        check("hold_until_frame", grant, 32'd0);
        cycle(1'b1, 1'b0);
        check("aligned_grant", grant, 32'b0010);
        check("aligned_ofs", owner_frame_start, 32'd1);
        check("aligned_pixel", pixel_data, 32'hF800);
        idle(1);
        check("ofs_single", owner_frame_start, 32'd0);

        // Release mid-frame with client 3 waiting
        req = 4'b1010;
        idle(3);
        cycle(1'b1, 1'b0);
        idle(2);
        req = 4'b1000;
        idle(3);
        check("release_held", grant, 32'b0010);
        cycle(1'b1, 1'b0);
        check("release_grant", grant, 32'b1000);
        check("release_fh", frames_held, 32'd0);

        // Quota rotation
        repeat (2) cycle(1'b0, 1'b1);
        req = 4'b0101;
        for (int i = 0; i < 7; i++) begin
            idle(2);
            cycle(1'b1, 1'b0);
            check("quota_owner", owner_id, qseq[i]);
        end

        // Sole requester saturates frames_held
        req = 4'b0100;
        for (int i = 0; i < 300; i++) begin
            idle(1);
            cycle(1'b1, 1'b0);
            check("sole_grant", grant, 32'b0100);
        end
        check("sole_saturate", frames_held, 32'd255);

        // Reset colliding with frame_begin while owned
        req = 4'b1111;
        cycle(1'b1, 1'b1);
        check("collide_grant", grant, 32'd0);
        idle(2);
        cycle(1'b1, 1'b0);
        check("collide_regrant", grant, 32'b0001);

        // Randomised traffic including back-to-back frames and stray resets
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) cdata[$urandom_range(0, N - 1)] = 16'($urandom);
            cycle($urandom_range(0, 4) == 0, $urandom_range(0, 79) == 0);
        end

        idle(2);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_frame_arbiter.md
# oled_frame_arbiter

Shares the single PMOD OLED pixel stream (96x64, RGB565) between up to `NUM_CLIENTS` pixel sources, such as the flag scroller, a badge UI layer and a test pattern. The arbiter sits between the `Oled_Display` driver and the clients. It takes the driver's `frame_begin` and `pixel_index`, and returns the granted client's `pixel_data`. Ownership changes only at frame boundaries, so a frame is never torn. Arbitration is round-robin with a per-owner frame quota.

## Interface
Parameters:
- `NUM_CLIENTS`, default 4: number of requesters, 2..8.
- `MAX_FRAMES`, default 60: frames an owner may hold while another client is waiting, 1..255.
- `IDLE_COLOR`, default 16'h0000: pixel value driven when no client is granted.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: display pixel clock (6.25 MHz domain).
- `reset` in 1: synchronous, active-high.
- `frame_begin` in 1: one-cycle pulse from `Oled_Display` at frame start.
- `pixel_index` in 13: from `Oled_Display`; passed through unchanged as `client_pixel_index`.
- `pixel_data` out 16: to `Oled_Display`.
- `req` in `NUM_CLIENTS`: level request, one bit per client.
- `client_pixel_data` in `16*NUM_CLIENTS`: client k drives bits [16k+15:16k].
- `client_pixel_index` out 13: broadcast copy of `pixel_index`.
- `grant` out `NUM_CLIENTS`: one-hot or zero.
- `grant_valid` out 1: OR of `grant`.
- `owner_id` out `$clog2(NUM_CLIENTS)`: index of the owner; 0 when not valid.
- `owner_frame_start` out 1: one-cycle pulse the cycle after every `frame_begin` while `grant_valid`.
- `frames_held` out 8: completed frame starts under the current owner, saturating at 255.

## Operation
There are two states: IDLE (no owner) and OWNED.

State updates happen only on a clock edge with `frame_begin`=1 and `reset`=0. All registers hold otherwise.

From IDLE:
- If `req`≠0: the winner is the first set bit searching from `last_owner+1` modulo N. Go to OWNED, set `grant`, `owner_id` and `last_owner` to the winner, and set `frames_held`=0.
- Otherwise stay in IDLE.

From OWNED with owner o:
- If `req[o]`=0: release. If another requester exists (round-robin from o+1), grant it directly with `frames_held`=0. Otherwise go to IDLE.
- If `req[o]`=1, another bit of `req` is set, and `frames_held+1 ≥ MAX_FRAMES`: rotate to the round-robin winner from o+1, with `frames_held`=0.
- Otherwise keep o and set `frames_held` to `frames_held+1`, saturating at 255.

Other rules:
- A deasserted `req` mid-frame does not drop `grant`. The client must keep its data valid until the next `frame_begin`.
- `pixel_data` is combinational: the granted client's slice, or `IDLE_COLOR` when `grant_valid`=0. The mux select is registered, so it is stable for the whole frame.
- `last_owner` resets to N-1, so client 0 wins the first arbitration.

## Timing
- Reset values: `grant`=0, `grant_valid`=0, `owner_id`=0, `frames_held`=0, `owner_frame_start`=0, `last_owner`=N-1, state IDLE. `pixel_data` becomes `IDLE_COLOR` from the cycle after reset.
- If `reset` and `frame_begin` are asserted together, reset wins and no grant occurs.
- If reset is asserted mid-frame while OWNED, the grant drops on the next edge.
- Grant latency: the new `grant` is visible the cycle after the `frame_begin` cycle. `owner_frame_start` pulses in that same cycle.
- `pixel_data` has 0-cycle latency from `client_pixel_data` (combinational path).
- `client_pixel_index` is a wire, with no register.
- Back-to-back `frame_begin` pulses are each treated as independent boundaries. The block does not check frame length.

## Structure
- Shared package `oled_pkg`:
  - `OLED_WIDTH`=96, `OLED_HEIGHT`=64, `OLED_PIXELS`=6144, `PIXEL_IDX_W`=13.
  - `rgb565_t` typedef.
  - Colour constants, including `IDLE_COLOR` defaults.
- Sub-module `oled_rr_pick`: combinational round-robin picker with inputs `req` and `start`, outputs `found` and `idx`. The release path and the rotate path both instantiate it.

## Test plan
- **Reset:** assert reset for 3 cycles with `req`=4'b1111. Expect `grant`=0 and `pixel_data`=16'h0000. At the first `frame_begin` after reset, expect `grant`=4'b0001.
- **Frame-aligned grant:** raise `req`=4'b0010 mid-frame with client 1 driving 16'hF800. Expect `grant` to stay 0 until `frame_begin`. The following cycle expect `grant`=4'b0010, a single `owner_frame_start` pulse, and `pixel_data`=16'hF800.
- **Release:** client 1 drops `req` mid-frame while `req[3]`=1. Expect `grant`=4'b0010 held until `frame_begin`, then `grant`=4'b1000 with `frames_held`=0.
- **Quota rotation:** with `MAX_FRAMES`=3 and `req`=4'b0101 held, expect ownership 0,0,0,2,2,2,0 across successive frames.
- **Sole requester:** with `req`=4'b0100 held for 300 frames, expect the grant never to change and `frames_held` to saturate at 255.
- **Reset collisions:** assert reset and `frame_begin` together while OWNED. Expect `grant`=0 the next cycle. At the following `frame_begin`, expect a grant with client 0 first.
